// File: rtl/vga_sync_gen_if.sv
// ---------------------------------------------------------------------------
// vga_sync_gen_if
// Bundle between the raster timing generator and the downstream pixel/VRAM
// stage.
//   Control (driven by the consumer): cli, enable_interrupt_on_hblank,
//     enable_interrupt_on_vblank, narrow_960, extra_vblank_lines_for_64mhz
//   Timing (driven by the generator): x[10:0], y[9:0], hsync, vsync,
//     retrace, blank, interrupt, and frame[7:0] when
//     VGA_SYNC_GEN_FRAME_COUNTER_EN is defined.
// master = generator side, slave = consumer side.
// ---------------------------------------------------------------------------
interface vga_sync_gen_if;
   logic        cli;
   logic        enable_interrupt_on_hblank;
   logic        enable_interrupt_on_vblank;
   logic        narrow_960;
   logic        extra_vblank_lines_for_64mhz;
   logic [10:0] x;
   logic [9:0]  y;
   logic        hsync;
   logic        vsync;
   logic        retrace;
   logic        blank;
   logic        interrupt;
`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
   logic [7:0]  frame;

   modport master (
      input  cli, enable_interrupt_on_hblank, enable_interrupt_on_vblank,
             narrow_960, extra_vblank_lines_for_64mhz,
      output x, y, hsync, vsync, retrace, blank, interrupt, frame
   );
   modport slave (
      output cli, enable_interrupt_on_hblank, enable_interrupt_on_vblank,
             narrow_960, extra_vblank_lines_for_64mhz,
      input  x, y, hsync, vsync, retrace, blank, interrupt, frame
   );
`else
   modport master (
      input  cli, enable_interrupt_on_hblank, enable_interrupt_on_vblank,
             narrow_960, extra_vblank_lines_for_64mhz,
      output x, y, hsync, vsync, retrace, blank, interrupt
   );
   modport slave (
      output cli, enable_interrupt_on_hblank, enable_interrupt_on_vblank,
             narrow_960, extra_vblank_lines_for_64mhz,
      input  x, y, hsync, vsync, retrace, blank, interrupt
   );
`endif
endinterface

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
// Free-running XGA-class raster timing generator.
//   clk     : pixel clock (nominally 64 MHz)
//   rst_n   : synchronous, active-low reset
//   sync_if : vga_sync_gen_if.master -- control inputs in, beam position,
//             sync pins, blank, retrace pulse and sticky interrupt out.
// Optional feature macro: VGA_SYNC_GEN_FRAME_COUNTER_EN adds an 8-bit
// frame counter (sync_if.frame) that steps on every frame wrap.
// x/y/interrupt are registers; the flags decode combinationally from the
// registered counters so they line up with x/y with zero latency.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
   parameter int H_ACTIVE      = 1024,
   parameter int H_FRONT       = 24,
   parameter int H_SYNC        = 136,
   parameter int H_BACK        = 160,
   parameter int V_ACTIVE      = 768,
   parameter int V_FRONT       = 3,
   parameter int V_SYNC        = 6,
   parameter int V_BACK        = 21,
   parameter int V_EXTRA       = 6,
   parameter int NARROW_MARGIN = 32,
   parameter int SYNC_NEG      = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   vga_sync_gen_if.master sync_if
);

   localparam logic [10:0] H_ACT       = 11'(H_ACTIVE);
   localparam logic [10:0] H_LAST      = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [10:0] HS_START    = 11'(H_ACTIVE + H_FRONT);
   localparam logic [10:0] HS_END      = 11'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [10:0] NAR_START   = 11'(NARROW_MARGIN);
   localparam logic [10:0] NAR_END     = 11'(H_ACTIVE - NARROW_MARGIN);
   localparam logic [9:0]  V_ACT       = 10'(V_ACTIVE);
   localparam logic [9:0]  V_ACT_M1    = 10'(V_ACTIVE - 1);
   localparam logic [9:0]  VS_START    = 10'(V_ACTIVE + V_FRONT);
   localparam logic [9:0]  VS_END      = 10'(V_ACTIVE + V_FRONT + V_SYNC);
   localparam logic [9:0]  V_LAST_BASE = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0]  V_LAST_EXT  = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK + V_EXTRA - 1);
   localparam logic        SYNC_INV    = (SYNC_NEG != 0);

   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic        ext_q, ext_d;     // frame-length mode latched at frame start
   logic        irq_q, irq_d;

   logic        x_last_s, y_last_s, hactive_s, set_h_s, set_v_s;
   logic        hs_act_s, vs_act_s, retrace_s, blank_s;
   logic [9:0]  v_last_s;
   logic [10:0] h_end_s;

   // Raster decode from the registered counters
   always_comb begin
      v_last_s  = ext_q ? V_LAST_EXT : V_LAST_BASE;
      x_last_s  = (x_q == H_LAST);
      y_last_s  = (y_q == v_last_s);
      // narrow_960 is used live, so a mode switch shows on the very next pixel
      hactive_s = sync_if.narrow_960 ? ((x_q >= NAR_START) && (x_q < NAR_END))
                                     : (x_q < H_ACT);
      h_end_s   = sync_if.narrow_960 ? NAR_END : H_ACT;
      blank_s   = !(hactive_s && (y_q < V_ACT));
      hs_act_s  = (x_q >= HS_START) && (x_q < HS_END);
      vs_act_s  = (y_q >= VS_START) && (y_q < VS_END);
      // the last line of the frame is followed by visible line 0
      retrace_s = x_last_s && ((y_q < V_ACT_M1) || y_last_s);
      set_h_s   = sync_if.enable_interrupt_on_hblank && (y_q < V_ACT) && (x_q == h_end_s);
      set_v_s   = sync_if.enable_interrupt_on_vblank && (y_q == V_ACT) && (x_q == 11'd0);
   end

   // Next-state for counters, latched frame mode and interrupt
   always_comb begin
      x_d   = x_q;
      y_d   = y_q;
      ext_d = ext_q;
      irq_d = irq_q;
      if (x_last_s) begin
         x_d = 11'd0;
         if (y_last_s) begin
            y_d   = 10'd0;
            // sample the mode only here so a frame never changes length midway
            ext_d = sync_if.extra_vblank_lines_for_64mhz;
         end else begin
            y_d = y_q + 10'd1;
         end
      end else begin
         x_d = x_q + 11'd1;
      end
      // a set event beats a simultaneous clear
      if (set_h_s || set_v_s) begin
         irq_d = 1'b1;
      end else if (sync_if.cli) begin
         irq_d = 1'b0;
      end else begin
         irq_d = irq_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q   <= 11'd0;
         y_q   <= 10'd0;
         ext_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         ext_q <= ext_d;
         irq_q <= irq_d;
      end
   end

`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
   logic [7:0] frame_q, frame_d;

   // Frame counter next-state: one step per frame wrap, natural 255 -> 0
   always_comb begin
      if (x_last_s && y_last_s) begin
         frame_d = frame_q + 8'd1;
      end else begin
         frame_d = frame_q;
      end
   end

   // Frame counter register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_q <= 8'd0;
      end else begin
         frame_q <= frame_d;
      end
   end

   assign sync_if.frame = frame_q;
`endif

   assign sync_if.x         = x_q;
   assign sync_if.y         = y_q;
   assign sync_if.hsync     = hs_act_s ^ SYNC_INV;
   assign sync_if.vsync     = vs_act_s ^ SYNC_INV;
   assign sync_if.retrace   = retrace_s;
   assign sync_if.blank     = blank_s;
   assign sync_if.interrupt = irq_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
// Two instances: u_xga uses the full XGA timing and is checked across its
// first two lines (horizontal decode, hblank interrupt, cli priority);
// u_small uses a scaled raster (104 x 30 / 36 lines) so whole frames fit in
// a short run (frame length, ext latching, retrace/vsync per frame, vblank
// interrupt, narrow mode).
// Scaled raster: H 64+8+16+16=104, narrow active 8..55, V 16+3+6+5=30,
// +6 extra = 36, vsync lines 19..24.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   cyc;

   vga_sync_gen_if g_if ();
   vga_sync_gen_if s_if ();

   vga_sync_gen u_xga (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_if (g_if)
   );

   vga_sync_gen #(
      .H_ACTIVE(64), .H_FRONT(8), .H_SYNC(16), .H_BACK(16),
      .V_ACTIVE(16), .V_FRONT(3), .V_SYNC(6), .V_BACK(5), .V_EXTRA(6),
      .NARROW_MARGIN(8), .SYNC_NEG(1)
   ) u_small (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_if (s_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== 32'(exp)) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) tick();
   endtask

   // advance the scaled instance to (ty,tx); an expired budget is a failure
   task automatic run_to(input string tag, input int ty, input int tx);
      int n;
      n = 0;
      while (!((s_if.x == 11'(tx)) && (s_if.y == 10'(ty))) && (n < 5000)) begin
         tick();
         n++;
      end
      if (n >= 5000) check_eq({tag, "_reach"}, 32'd0, 1);
   endtask

   // run one full frame of the scaled instance and collect per-frame stats
   task automatic run_frame(input string tag, input int exp_len, input int exp_last, input bit drop);
      int n, maxy, rt, rt_vbl, vs, vs_bad;
      n = 0; maxy = 0; rt = 0; rt_vbl = 0; vs = 0; vs_bad = 0;
      do begin
         tick();
         n++;
         if (int'(s_if.y) > maxy) maxy = int'(s_if.y);
         if (s_if.retrace) begin
            rt++;
            if ((s_if.y >= 10'd16) && (int'(s_if.y) < exp_last)) rt_vbl++;
         end
         if (!s_if.vsync) begin
            vs++;
            if ((s_if.y < 10'd19) || (s_if.y > 10'd24)) vs_bad++;
         end
         if (drop && (s_if.y == 10'd32)) s_if.extra_vblank_lines_for_64mhz = 1'b0;
      end while (!((s_if.x == 11'd0) && (s_if.y == 10'd0)) && (n < 5000));
      check_eq({tag, "_len"}, n, exp_len);
      check_eq({tag, "_maxy"}, maxy, exp_last);
      check_eq({tag, "_retrace"}, rt, 16);
      check_eq({tag, "_retrace_vbl"}, rt_vbl, 0);
      check_eq({tag, "_vsync_cyc"}, vs, 624);
      check_eq({tag, "_vsync_bad"}, vs_bad, 0);
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      rst_n = 1'b0;
      g_if.cli = 1'b0; g_if.enable_interrupt_on_hblank = 1'b0;
      g_if.enable_interrupt_on_vblank = 1'b0; g_if.narrow_960 = 1'b0;
      g_if.extra_vblank_lines_for_64mhz = 1'b0;
      s_if.cli = 1'b0; s_if.enable_interrupt_on_hblank = 1'b0;
      s_if.enable_interrupt_on_vblank = 1'b0; s_if.narrow_960 = 1'b0;
      s_if.extra_vblank_lines_for_64mhz = 1'b0;

      // reset state
      repeat (3) tick();
      check_eq("rst_x", g_if.x, 0);
      check_eq("rst_y", g_if.y, 0);
      check_eq("rst_blank", g_if.blank, 0);
      check_eq("rst_hsync", g_if.hsync, 1);
      check_eq("rst_vsync", g_if.vsync, 1);
      check_eq("rst_retrace", g_if.retrace, 0);
      check_eq("rst_irq", g_if.interrupt, 0);
      check_eq("rst_s_x", s_if.x, 0);
      check_eq("rst_s_y", s_if.y, 0);
`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
      check_eq("rst_frame", s_if.frame, 0);
`endif
      rst_n = 1'b1;
      cyc = 0;

      // XGA line 0: after release x equals the cycle count
      to_cyc(31);  g_if.narrow_960 = 1'b1; #1;
      check_eq("nar_blank_31", g_if.blank, 1);
      to_cyc(32);  check_eq("nar_blank_32", g_if.blank, 0);
      to_cyc(991); check_eq("nar_blank_991", g_if.blank, 0);
      to_cyc(992); check_eq("nar_blank_992", g_if.blank, 1);
      to_cyc(1000); g_if.enable_interrupt_on_hblank = 1'b1;
      to_cyc(1023); g_if.narrow_960 = 1'b0; #1;
      check_eq("x_1023", g_if.x, 1023);
      check_eq("blank_1023", g_if.blank, 0);
      to_cyc(1024);
      check_eq("blank_1024", g_if.blank, 1);
      check_eq("irq_at_1024", g_if.interrupt, 0);
      to_cyc(1025); check_eq("irq_after_1024", g_if.interrupt, 1);
      to_cyc(1047); check_eq("hsync_1047", g_if.hsync, 1);
      to_cyc(1048); check_eq("hsync_1048", g_if.hsync, 0);
      to_cyc(1100); g_if.cli = 1'b1;
      to_cyc(1101); g_if.cli = 1'b0;
      check_eq("irq_cli", g_if.interrupt, 0);
      to_cyc(1183); g_if.narrow_960 = 1'b1; #1;
      check_eq("nar_hsync_1183", g_if.hsync, 0);
      to_cyc(1184); check_eq("nar_hsync_1184", g_if.hsync, 1);
      g_if.narrow_960 = 1'b0;
      to_cyc(1343);
      check_eq("x_last", g_if.x, 1343);
      check_eq("retrace_line0", g_if.retrace, 1);
      to_cyc(1344);
      check_eq("x_wrap", g_if.x, 0);
      check_eq("y_step", g_if.y, 1);
      check_eq("retrace_off", g_if.retrace, 0);
      to_cyc(2368);
      check_eq("irq_pre_setwin", g_if.interrupt, 0);
      g_if.cli = 1'b1;
      to_cyc(2369);
      g_if.cli = 1'b0;
      check_eq("irq_set_wins", g_if.interrupt, 1);
      g_if.enable_interrupt_on_hblank = 1'b0;
      to_cyc(2380); check_eq("irq_sticky_dis", g_if.interrupt, 1);

      // scaled raster: restart from reset with ext low, then request ext
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      s_if.extra_vblank_lines_for_64mhz = 1'b1;
      run_frame("f0", 3120, 29, 1'b0);
`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
      check_eq("frame_f0", s_if.frame, 1);
`endif
      run_frame("f1", 3744, 35, 1'b1);
      run_frame("f2", 3120, 29, 1'b0);
`ifdef VGA_SYNC_GEN_FRAME_COUNTER_EN
      check_eq("frame_f2", s_if.frame, 3);
`endif

      // vblank interrupt: single set at (V_ACTIVE, 0)
      s_if.enable_interrupt_on_vblank = 1'b1;
      run_to("v0", 16, 0);
      check_eq("virq_at", s_if.interrupt, 0);
      tick();
      check_eq("virq_rise", s_if.interrupt, 1);
      run_to("v5", 16, 5);
      s_if.cli = 1'b1;
      tick();
      s_if.cli = 1'b0;
      check_eq("virq_cli", s_if.interrupt, 0);
      run_to("v17", 17, 1);
      check_eq("virq_once", s_if.interrupt, 0);
      check_eq("vbl_blank", s_if.blank, 1);

      // narrow mode on the scaled raster plus hblank interrupt at 56
      s_if.enable_interrupt_on_vblank = 1'b0;
      s_if.enable_interrupt_on_hblank = 1'b1;
      s_if.narrow_960 = 1'b1;
      run_to("h20", 20, 57);
      check_eq("hirq_vbl_none", s_if.interrupt, 0);
      run_to("n7", 0, 7);
      check_eq("s_nar_blank_7", s_if.blank, 1);
      tick();
      check_eq("s_nar_blank_8", s_if.blank, 0);
      run_to("n55", 0, 55);
      check_eq("s_nar_blank_55", s_if.blank, 0);
      tick();
      check_eq("s_nar_blank_56", s_if.blank, 1);
      check_eq("s_hirq_at", s_if.interrupt, 0);
      tick();
      check_eq("s_hirq_rise", s_if.interrupt, 1);
      s_if.enable_interrupt_on_hblank = 1'b0;
      run_to("n70", 0, 70);
      check_eq("s_hirq_sticky", s_if.interrupt, 1);

      // reset in mid-run clears counters and the pending interrupt
      rst_n = 1'b0;
      tick();
      check_eq("rst2_x", s_if.x, 0);
      check_eq("rst2_y", s_if.y, 0);
      check_eq("rst2_irq", s_if.interrupt, 0);
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
